// File: rtl/uart_loopback_bist.sv
// uart_loopback_bist
//   Built-in self-test sequencer placed between a uart_tx and a uart_rx wired
//   in loopback. Sends NUM_FRAMES pattern words (incrementing or Fibonacci
//   LFSR), checks every received word against the one sent and accumulates
//   saturating mismatch / frame-error / timeout counts. pass is the sticky
//   result of the last completed run.
//
//   Optional feature, macro UART_BIST_CAPTURE_EN: adds first_err_* outputs that
//   latch the first data mismatch of a run (index = sent_count at that moment).
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   start               one-cycle pulse, begins a run when idle
//   tx_valid/data/ready word offered to the transmitter (valid/ready handshake)
//   rx_data/valid       received word and its one-cycle strobe
//   rx_frame_error      stop-bit error, qualified by rx_valid
//   busy, done, pass    run in progress, end-of-run pulse, sticky result
//   sent_count          words accepted by the transmitter this run
//   err_count           data mismatches plus spurious words (saturating)
//   frame_err_count     frame errors (saturating)
//   timeout_count       per-word receive timeouts (saturating)
module uart_loopback_bist #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned NUM_FRAMES     = 16,
    parameter logic [31:0] SEED           = 32'hAB,
    parameter int unsigned PATTERN        = 0,
    parameter int unsigned GAP_CYCLES     = 900,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_frame_error,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       sent_count,
    output logic [15:0]       err_count,
    output logic [15:0]       frame_err_count,
`ifdef UART_BIST_CAPTURE_EN
    output logic              first_err_valid,
    output logic [15:0]       first_err_index,
    output logic [DATA_W-1:0] first_err_expected,
    output logic [DATA_W-1:0] first_err_received,
`endif
    output logic [15:0]       timeout_count
);

    // Maximal-length Fibonacci taps, shift-left form: bit (n-1) set for tap n.
    function automatic logic [31:0] lfsr_taps(input int unsigned w);
        case (w)
            2:       return 32'h3;
            3:       return 32'h6;
            4:       return 32'hC;
            5:       return 32'h14;
            6:       return 32'h30;
            7:       return 32'h60;
            8:       return 32'hB8;
            9:       return 32'h110;
            10:      return 32'h240;
            11:      return 32'h500;
            12:      return 32'h829;
            13:      return 32'h100D;
            14:      return 32'h2015;
            15:      return 32'h6000;
            16:      return 32'hD008;
            default: return 32'h3 << (w - 2);
        endcase
    endfunction

    localparam logic [DATA_W-1:0] TAPS   = DATA_W'(lfsr_taps(DATA_W));
    localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);
    // An all-zero LFSR never leaves zero, so that seed is replaced by 1.
    localparam logic [DATA_W-1:0] SEED_EFF =
        (PATTERN == 1 && SEED_W == '0) ? DATA_W'(1) : SEED_W;

    function automatic logic [DATA_W-1:0] next_pattern(input logic [DATA_W-1:0] p);
        if (PATTERN == 0) return p + DATA_W'(1);
        else              return {p[DATA_W-2:0], ^(p & TAPS)};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    typedef enum logic [2:0] {IDLE, GAP, SEND, WAIT_RX, NEXT} state_t;

    state_t            state;
    logic [31:0]       gap_cnt;
    logic [31:0]       to_cnt;
    logic [DATA_W-1:0] pattern;
    logic [DATA_W-1:0] expected;

    logic        rx_hit, mismatch, spurious, timeout_hit;
    logic [15:0] err_nxt, frame_nxt, tmo_nxt;

    // Counter updates are shared by every state; rx_valid outside WAIT_RX is
    // a spurious word. A receive on the timeout cycle takes precedence.
    always_comb begin
        rx_hit      = (state == WAIT_RX) && rx_valid;
        mismatch    = rx_hit && !rx_frame_error && (rx_data != expected);
        spurious    = (state != WAIT_RX) && rx_valid;
        timeout_hit = (state == WAIT_RX) && !rx_valid && (to_cnt == TIMEOUT_CYCLES - 1);
        err_nxt     = sat_inc(err_count, mismatch || spurious);
        frame_nxt   = sat_inc(frame_err_count, rx_hit && rx_frame_error);
        tmo_nxt     = sat_inc(timeout_count, timeout_hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            to_cnt          <= '0;
            pattern         <= SEED_EFF;
            expected        <= '0;
            tx_valid        <= 1'b0;
            tx_data         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            sent_count      <= '0;
            err_count       <= '0;
            frame_err_count <= '0;
            timeout_count   <= '0;
`ifdef UART_BIST_CAPTURE_EN
            first_err_valid    <= 1'b0;
            first_err_index    <= '0;
            first_err_expected <= '0;
            first_err_received <= '0;
`endif
        end else begin
            done            <= 1'b0;
            err_count       <= err_nxt;
            frame_err_count <= frame_nxt;
            timeout_count   <= tmo_nxt;
`ifdef UART_BIST_CAPTURE_EN
            if (mismatch && !first_err_valid) begin
                first_err_valid    <= 1'b1;
                first_err_index    <= sent_count;
                first_err_expected <= expected;
                first_err_received <= rx_data;
            end
`endif
            case (state)
                IDLE: if (start) begin
                    // Later assignments override the counter updates above.
                    sent_count      <= '0;
                    err_count       <= '0;
                    frame_err_count <= '0;
                    timeout_count   <= '0;
                    pass            <= 1'b0;
                    pattern         <= SEED_EFF;
                    busy            <= 1'b1;
                    gap_cnt         <= '0;
                    state           <= GAP;
`ifdef UART_BIST_CAPTURE_EN
                    first_err_valid    <= 1'b0;
                    first_err_index    <= '0;
                    first_err_expected <= '0;
                    first_err_received <= '0;
`endif
                end
                GAP: begin
                    if (gap_cnt == GAP_CYCLES) begin
                        tx_valid <= 1'b1;
                        tx_data  <= pattern;
                        state    <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                SEND: if (tx_ready) begin
                    sent_count <= sat_inc(sent_count, 1'b1);
                    expected   <= pattern;
                    tx_valid   <= 1'b0;
                    to_cnt     <= '0;
                    state      <= WAIT_RX;
                end
                WAIT_RX: begin
                    if (rx_valid || timeout_hit) state <= NEXT;
                    else                         to_cnt <= to_cnt + 32'd1;
                end
                NEXT: begin
                    pattern <= next_pattern(pattern);
                    if (sent_count == 16'(NUM_FRAMES)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0) && (frame_nxt == '0) && (tmo_nxt == '0);
                        state <= IDLE;
                    end else begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loopback_bist.sv
// Self-checking bench for uart_loopback_bist. Instance A (incrementing pattern,
// SEED AB) is driven by a loopback responder whose per-word behaviour comes from
// small tables; instance B (LFSR, SEED 0) checks the seed-forcing rule.
module tb_uart_loopback_bist;

    localparam int GAP_A = 5;
    localparam int TO_A  = 50;
    localparam int NW    = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // instance A
    logic        a_start, a_tx_valid, a_tx_ready, a_rx_valid, a_rx_frame_error;
    logic        a_busy, a_done, a_pass;
    logic [7:0]  a_tx_data, a_rx_data;
    logic [15:0] a_sent_count, a_err_count, a_frame_err_count, a_timeout_count;
`ifdef UART_BIST_CAPTURE_EN
    logic        a_fe_valid;
    logic [15:0] a_fe_index;
    logic [7:0]  a_fe_expected, a_fe_received;
    logic        b_fe_valid;
    logic [15:0] b_fe_index;
    logic [7:0]  b_fe_expected, b_fe_received;
`endif
    // instance B
    logic        b_start, b_tx_valid, b_tx_ready, b_rx_valid, b_rx_frame_error;
    logic        b_busy, b_done, b_pass;
    logic [7:0]  b_tx_data, b_rx_data;
    logic [15:0] b_sent_count, b_err_count, b_frame_err_count, b_timeout_count;

    uart_loopback_bist #(.DATA_W(8), .NUM_FRAMES(NW), .SEED(32'hAB), .PATTERN(0),
                         .GAP_CYCLES(GAP_A), .TIMEOUT_CYCLES(TO_A)) dut_a (
        .clk(clk), .reset(reset), .start(a_start),
        .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(a_tx_ready),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_frame_error(a_rx_frame_error),
        .busy(a_busy), .done(a_done), .pass(a_pass), .sent_count(a_sent_count),
        .err_count(a_err_count), .frame_err_count(a_frame_err_count),
`ifdef UART_BIST_CAPTURE_EN
        .first_err_valid(a_fe_valid), .first_err_index(a_fe_index),
        .first_err_expected(a_fe_expected), .first_err_received(a_fe_received),
`endif
        .timeout_count(a_timeout_count));

    uart_loopback_bist #(.DATA_W(8), .NUM_FRAMES(NW), .SEED(32'h0), .PATTERN(1),
                         .GAP_CYCLES(3), .TIMEOUT_CYCLES(TO_A)) dut_b (
        .clk(clk), .reset(reset), .start(b_start),
        .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(b_tx_ready),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_frame_error(b_rx_frame_error),
        .busy(b_busy), .done(b_done), .pass(b_pass), .sent_count(b_sent_count),
        .err_count(b_err_count), .frame_err_count(b_frame_err_count),
`ifdef UART_BIST_CAPTURE_EN
        .first_err_valid(b_fe_valid), .first_err_index(b_fe_index),
        .first_err_expected(b_fe_expected), .first_err_received(b_fe_received),
`endif
        .timeout_count(b_timeout_count));

    // Per-word responder behaviour: mode 0 echo, 1 corrupt (xor flip), 2 frame
    // error, 3 never answer. rx_delay d puts rx_valid d+1 cycles after handshake.
    int         mode[NW];
    int         rx_delay[NW];
    int         ready_delay[NW];
    logic [7:0] flip[NW];

    // Observations of the last run_a.
    logic [7:0] sent_q[$];
    int         done_pulses, done_cycle;
    bit         tx_unstable, valid_drop, cnt_bad, run_expired;

    // Plays transmitter and loopback receiver for one run of instance A.
    task automatic run_a(input int budget);
        int cyc, k, rdy_wait, rx_cnt, rx_mode;
        bit pending, have_held, prev_vld, prev_hs, hs;
        logic [7:0] held, rx_word;
        sent_q.delete();
        done_pulses = 0; done_cycle = -1;
        tx_unstable = 0; valid_drop = 0; cnt_bad = 0; run_expired = 0;
        k = 0; rdy_wait = 0; rx_cnt = 0; rx_mode = 0; pending = 0; have_held = 0;
        prev_vld = 0; prev_hs = 0; held = '0; rx_word = '0;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk); cyc++;
            if (a_done) begin done_pulses++; if (done_cycle < 0) done_cycle = cyc; end
            if (a_sent_count !== 16'(sent_q.size())) cnt_bad = 1;
            if (prev_vld && !prev_hs && !a_tx_valid) valid_drop = 1;
            a_rx_valid = 1'b0; a_rx_frame_error = 1'b0; a_rx_data = 8'($urandom);
            if (pending) begin
                if (rx_cnt == 0) begin
                    pending = 0;
                    a_rx_valid = 1'b1;
                    a_rx_data = rx_word;
                    a_rx_frame_error = (rx_mode == 2);
                end else rx_cnt--;
            end
            hs = 0;
            if (a_tx_valid) begin
                if (have_held && a_tx_data !== held) tx_unstable = 1;
                held = a_tx_data; have_held = 1;
                if (k < NW && rdy_wait >= ready_delay[k]) begin a_tx_ready = 1'b1; hs = 1; end
                else begin a_tx_ready = 1'b0; rdy_wait++; end
            end else a_tx_ready = 1'b0;
            if (hs) begin
                sent_q.push_back(held);
                if (mode[k] != 3) begin
                    pending = 1; rx_cnt = rx_delay[k]; rx_mode = mode[k];
                    rx_word = (mode[k] == 1) ? held ^ flip[k] : (mode[k] == 2) ? held ^ 8'h5A : held;
                end
                k++; rdy_wait = 0; have_held = 0;
            end
            prev_vld = a_tx_valid; prev_hs = hs;
            if (done_cycle >= 0 && cyc >= done_cycle + 3) break;
            if (cyc >= budget) begin run_expired = 1; break; end
        end
        a_tx_ready = 1'b0; a_rx_valid = 1'b0; a_rx_frame_error = 1'b0;
    endtask

    task automatic set_words(input int m, input int d, input int r);
        for (int i = 0; i < NW; i++) begin
            mode[i] = m; rx_delay[i] = d; ready_delay[i] = r; flip[i] = 8'h00;
        end
    endtask

    task automatic test_reset();
        checks++; if ({a_tx_valid, a_busy, a_done, a_pass} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {a_tx_valid, a_busy, a_done, a_pass}); end
        checks++; if (a_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", a_tx_data); end
        checks++; if ({a_sent_count, a_err_count, a_frame_err_count, a_timeout_count} !== 64'd0) begin errors++; $display("FAIL reset_counters got %h want 0", {a_sent_count, a_err_count, a_frame_err_count, a_timeout_count}); end
    endtask

    task automatic test_ideal();
        logic [7:0] w;
        set_words(0, 9, 0);
        run_a(2000);
        checks++; if (run_expired) begin errors++; $display("FAIL ideal_done_timeout got expired want done"); end
        for (int i = 0; i < NW; i++) begin
            w = 8'hAB + 8'(i);
            checks++; if (sent_q[i] !== w) begin errors++; $display("FAIL ideal_word%0d got %h want %h", i, sent_q[i], w); end
        end
        checks++; if (a_sent_count !== 16'd4) begin errors++; $display("FAIL ideal_sent got %0d want 4", a_sent_count); end
        checks++; if ({a_err_count, a_frame_err_count, a_timeout_count} !== 48'd0) begin errors++; $display("FAIL ideal_errs got %h want 0", {a_err_count, a_frame_err_count, a_timeout_count}); end
        checks++; if (a_pass !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL ideal_pass_busy got %b%b want 10", a_pass, a_busy); end
        checks++; if (done_pulses !== 1) begin errors++; $display("FAIL ideal_done_pulses got %0d want 1", done_pulses); end
        checks++; if (cnt_bad) begin errors++; $display("FAIL ideal_sent_tracking got bad want handshake-only"); end
`ifdef UART_BIST_CAPTURE_EN
        checks++; if (a_fe_valid !== 1'b0) begin errors++; $display("FAIL ideal_capture_valid got %b want 0", a_fe_valid); end
`endif
    endtask

    task automatic test_bit_flip();
        set_words(0, 9, 0);
        mode[2] = 1; flip[2] = 8'h80;   // AD arrives as 2D
        run_a(2000);
        checks++; if (run_expired) begin errors++; $display("FAIL flip_done_timeout got expired want done"); end
        checks++; if (a_err_count !== 16'd1) begin errors++; $display("FAIL flip_err got %0d want 1", a_err_count); end
        checks++; if (a_frame_err_count !== 16'd0 || a_timeout_count !== 16'd0) begin errors++; $display("FAIL flip_other got %0d/%0d want 0/0", a_frame_err_count, a_timeout_count); end
        checks++; if (a_pass !== 1'b0) begin errors++; $display("FAIL flip_pass got %b want 0", a_pass); end
`ifdef UART_BIST_CAPTURE_EN
        checks++; if (a_fe_valid !== 1'b1 || a_fe_index !== 16'd3) begin errors++; $display("FAIL flip_capture_idx got %b/%0d want 1/3", a_fe_valid, a_fe_index); end
        checks++; if (a_fe_expected !== 8'hAD || a_fe_received !== 8'h2D) begin errors++; $display("FAIL flip_capture_data got %h/%h want AD/2D", a_fe_expected, a_fe_received); end
`endif
    endtask

    task automatic test_frame_error();
        set_words(0, 9, 0);
        mode[1] = 2;
        run_a(2000);
        checks++; if (a_frame_err_count !== 16'd1) begin errors++; $display("FAIL frame_cnt got %0d want 1", a_frame_err_count); end
        checks++; if (a_err_count !== 16'd0) begin errors++; $display("FAIL frame_err_cnt got %0d want 0", a_err_count); end
        checks++; if (a_pass !== 1'b0 || done_pulses !== 1) begin errors++; $display("FAIL frame_pass_done got %b/%0d want 0/1", a_pass, done_pulses); end
`ifdef UART_BIST_CAPTURE_EN
        checks++; if (a_fe_valid !== 1'b0) begin errors++; $display("FAIL frame_capture got %b want 0", a_fe_valid); end
`endif
    endtask

    task automatic test_timeout();
        int exp_cyc;
        set_words(3, 0, 0);
        run_a(2000);
        exp_cyc = NW * ((GAP_A + 1) + 1 + TO_A + 1);
        checks++; if (a_timeout_count !== 16'(NW)) begin errors++; $display("FAIL timeout_cnt got %0d want %0d", a_timeout_count, NW); end
        checks++; if (done_cycle !== exp_cyc) begin errors++; $display("FAIL timeout_done_cycle got %0d want %0d", done_cycle, exp_cyc); end
        checks++; if (a_pass !== 1'b0 || a_err_count !== 16'd0) begin errors++; $display("FAIL timeout_pass_err got %b/%0d want 0/0", a_pass, a_err_count); end
    endtask

    task automatic test_timeout_boundary();
        // rx on the very timeout cycle: receive wins, no timeout
        set_words(0, 5, 0);
        rx_delay[0] = TO_A - 1;
        run_a(2000);
        checks++; if (a_timeout_count !== 16'd0 || a_err_count !== 16'd0 || a_pass !== 1'b1) begin errors++; $display("FAIL tmo_edge_win got to=%0d err=%0d pass=%b want 0 0 1", a_timeout_count, a_err_count, a_pass); end
        // one cycle later: timeout, then the late word is spurious
        rx_delay[0] = TO_A;
        run_a(2000);
        checks++; if (a_timeout_count !== 16'd1 || a_err_count !== 16'd1 || a_pass !== 1'b0) begin errors++; $display("FAIL tmo_edge_late got to=%0d err=%0d pass=%b want 1 1 0", a_timeout_count, a_err_count, a_pass); end
    endtask

    task automatic test_stall();
        set_words(0, 9, 0);
        ready_delay[0] = 200;
        run_a(3000);
        checks++; if (tx_unstable) begin errors++; $display("FAIL stall_data_stable got changed want stable"); end
        checks++; if (valid_drop) begin errors++; $display("FAIL stall_valid_held got dropped want held"); end
        checks++; if (cnt_bad) begin errors++; $display("FAIL stall_sent_tracking got early want handshake-only"); end
        checks++; if (sent_q[0] !== 8'hAB || a_sent_count !== 16'd4 || a_pass !== 1'b1) begin errors++; $display("FAIL stall_result got %h/%0d/%b want AB/4/1", sent_q[0], a_sent_count, a_pass); end
    endtask

    task automatic test_random();
        int e_err, e_fe, e_to;
        logic [7:0] w;
        for (int run = 0; run < 6; run++) begin
            e_err = 0; e_fe = 0; e_to = 0;
            for (int i = 0; i < NW; i++) begin
                mode[i] = int'($urandom_range(0, 3));
                rx_delay[i] = int'($urandom_range(0, 40));
                ready_delay[i] = int'($urandom_range(0, 6));
                flip[i] = 8'($urandom_range(1, 255));
                if (mode[i] == 1) e_err++;
                if (mode[i] == 2) e_fe++;
                if (mode[i] == 3) e_to++;
            end
            run_a(2000);
            for (int i = 0; i < NW; i++) begin
                w = 8'hAB + 8'(i);
                checks++; if (sent_q[i] !== w) begin errors++; $display("FAIL rand%0d_word%0d got %h want %h", run, i, sent_q[i], w); end
            end
            checks++; if (a_err_count !== 16'(e_err) || a_frame_err_count !== 16'(e_fe) || a_timeout_count !== 16'(e_to)) begin errors++; $display("FAIL rand%0d_counts got %0d/%0d/%0d want %0d/%0d/%0d", run, a_err_count, a_frame_err_count, a_timeout_count, e_err, e_fe, e_to); end
            checks++; if (a_pass !== (e_err + e_fe + e_to == 0) || done_pulses !== 1) begin errors++; $display("FAIL rand%0d_pass_done got %b/%0d want %b/1", run, a_pass, done_pulses, (e_err + e_fe + e_to == 0)); end
        end
    endtask

    task automatic test_spurious();
        set_words(0, 9, 0);
        run_a(2000);
        @(negedge clk); a_rx_valid = 1'b1; a_rx_data = 8'hAB;
        @(negedge clk); a_rx_valid = 1'b0;
        checks++; if (a_err_count !== 16'd1) begin errors++; $display("FAIL spurious_err got %0d want 1", a_err_count); end
        checks++; if (a_pass !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL spurious_state got %b%b want 10", a_pass, a_busy); end
    endtask

    task automatic test_reset_midrun();
        int hs_n, dn, cyc;
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        a_tx_ready = 1'b1; hs_n = 0; cyc = 0;
        while (hs_n < 3 && cyc < 1000) begin
            @(negedge clk); cyc++;
            if (a_tx_valid) hs_n++;
        end
        @(negedge clk); @(negedge clk);
        a_tx_ready = 1'b0;
        checks++; if (a_sent_count !== 16'd3 || a_busy !== 1'b1) begin errors++; $display("FAIL rst_pre got %0d/%b want 3/1", a_sent_count, a_busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if ({a_tx_valid, a_busy, a_done, a_pass, a_tx_data} !== 12'd0) begin errors++; $display("FAIL rst_mid_flags got %h want 0", {a_tx_valid, a_busy, a_done, a_pass, a_tx_data}); end
        checks++; if ({a_sent_count, a_err_count, a_frame_err_count, a_timeout_count} !== 64'd0) begin errors++; $display("FAIL rst_mid_counters got %h want 0", {a_sent_count, a_err_count, a_frame_err_count, a_timeout_count}); end
        dn = 0;
        for (int i = 0; i < 120; i++) begin @(negedge clk); if (a_done || a_tx_valid) dn++; end
        checks++; if (dn !== 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", dn); end
    endtask

    task automatic test_lfsr_seed0();
        logic [7:0] words[$];
        logic [7:0] w;
        logic [7:0] exp_w[NW];
        bit fire;
        int dn, cyc;
        exp_w[0] = 8'h01; exp_w[1] = 8'h02; exp_w[2] = 8'h04; exp_w[3] = 8'h08;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        b_tx_ready = 1'b1; fire = 0; dn = 0; cyc = 0; w = '0;
        while (dn == 0 && cyc < 1000) begin
            @(negedge clk); cyc++;
            b_rx_valid = fire; b_rx_data = w; fire = 0;
            if (b_done) dn = 1;
            if (b_tx_valid) begin words.push_back(b_tx_data); w = b_tx_data; fire = 1; end
        end
        b_tx_ready = 1'b0; b_rx_valid = 1'b0;
        checks++; if (dn !== 1) begin errors++; $display("FAIL lfsr_done got %0d want 1", dn); end
        for (int i = 0; i < NW; i++) begin
            checks++; if (words[i] !== exp_w[i]) begin errors++; $display("FAIL lfsr_word%0d got %h want %h", i, words[i], exp_w[i]); end
        end
        checks++; if (b_pass !== 1'b1 || b_err_count !== 16'd0 || b_sent_count !== 16'd4) begin errors++; $display("FAIL lfsr_result got %b/%0d/%0d want 1/0/4", b_pass, b_err_count, b_sent_count); end
    endtask

    initial begin
        reset = 1'b1;
        a_start = 0; a_tx_ready = 0; a_rx_valid = 0; a_rx_frame_error = 0; a_rx_data = '0;
        b_start = 0; b_tx_ready = 0; b_rx_valid = 0; b_rx_frame_error = 0; b_rx_data = '0;
        set_words(0, 9, 0);
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_ideal();
        test_bit_flip();
        test_frame_error();
        test_timeout();
        test_timeout_boundary();
        test_stall();
        test_random();
        test_spurious();
        test_reset_midrun();
        test_lfsr_seed0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_loopback_bist.md
Name: uart_loopback_bist

Overview:
Synthesizable, parametrised built-in self-test sequencer for the UART pair. It drives a uart_tx-style valid/ready/data interface with a generated pattern and consumes uart_rx-style data/valid/frame_error outputs. Every received word is checked against the word sent, and mismatch, frame-error and timeout counts are accumulated. It sits between the two UART blocks in loopback and replaces hand-written stimulus with an on-chip pass/fail result.

Parameters:
DATA_W, 8, width of the tx/rx data words.
NUM_FRAMES, 16, words sent per run (1..65535).
SEED, 8'hAB, first pattern word; truncated or zero-extended to DATA_W.
PATTERN, 0, 0 = incrementing (+1 mod 2^DATA_W); 1 = Fibonacci LFSR (taps x^8+x^6+x^5+x^4+1 for DATA_W=8, and the maximal-length taps table for other widths).
GAP_CYCLES, 900, idle cycles before each transmit (0 allowed).
TIMEOUT_CYCLES, 100000, maximum cycles spent waiting for rx_valid per word.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins a run when idle
tx_valid  output  1  word offered to transmitter
tx_data  output  DATA_W  word offered to transmitter
tx_ready  input  1  transmitter accepts when high with tx_valid
rx_data  input  DATA_W  received word
rx_valid  input  1  received word strobe (one cycle)
rx_frame_error  input  1  receiver stop-bit error, qualified by rx_valid
busy  output  1  run in progress
done  output  1  one-cycle pulse at run end
pass  output  1  sticky result of last run; 1 iff all error counters are zero
sent_count  output  16  words accepted by transmitter this run
err_count  output  16  data mismatches (saturating)
frame_err_count  output  16  frame errors (saturating)
timeout_count  output  16  per-word timeouts (saturating)

Behaviour:
- Reset: all outputs 0. State = IDLE; pattern register = SEED.
- States: IDLE, GAP, SEND, WAIT_RX, NEXT.
- IDLE: start=1 clears all counters and pass, loads pattern = SEED, sets busy=1, goes to GAP. start is ignored outside IDLE.
- GAP: count GAP_CYCLES cycles, then go to SEND. With GAP_CYCLES=0, SEND is entered on the next cycle.
- SEND:
  - tx_valid=1, tx_data=pattern.
  - tx_data is held stable until tx_valid && tx_ready.
  - On the handshake: sent_count+1, expected = pattern, tx_valid drops the following cycle, go to WAIT_RX.
- WAIT_RX:
  - On rx_valid: if rx_frame_error, frame_err_count+1 and no data compare; otherwise a compare with rx_data != expected gives err_count+1. Go to NEXT.
  - If no rx_valid after TIMEOUT_CYCLES cycles: timeout_count+1, go to NEXT.
  - If rx_valid and timeout coincide on the same cycle, rx_valid wins.
- NEXT: advance pattern per PATTERN.
  - If sent_count == NUM_FRAMES: busy=0, done=1 for one cycle, pass = (all three error counters == 0), go to IDLE.
  - Otherwise go to GAP.
- rx_valid outside WAIT_RX is a spurious word: err_count+1, no state change.
- Counters saturate at 16'hFFFF.
- LFSR mode with SEED=0 is forced to seed 1, so the LFSR cannot lock up.
- Reset mid-run: run is aborted the next cycle, all outputs return to reset values, no done pulse.
- Latency: first tx_valid rises GAP_CYCLES+1 cycles after the start pulse.

Optional Feature:
Macro UART_BIST_CAPTURE_EN.
- Defined: adds outputs first_err_valid (1), first_err_index (16), first_err_expected (DATA_W), first_err_received (DATA_W).
  - These latch the first data mismatch of a run: index = sent_count at that moment.
  - They are cleared on start and on reset.
  - A frame error, timeout or spurious word does not capture.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
1. Ideal loopback (rx returns tx_data 10 cycles after the handshake), DATA_W=8, SEED=8'hAB, PATTERN=0, NUM_FRAMES=4 -> tx_data AB, AC, AD, AE; sent_count=4; all error counts 0; done pulses once; pass=1.
2. Bit flip on word 2 (received 8'h2D instead of 8'hAD) -> err_count=1, pass=0. With UART_BIST_CAPTURE_EN: first_err_index=3, expected=AD, received=2D.
3. rx_frame_error=1 on word 1 -> frame_err_count=1, err_count=0, pass=0.
4. rx never responds, TIMEOUT_CYCLES=50, NUM_FRAMES=2 -> timeout_count=2; done occurs after 2*(GAP+handshake+50) cycles; pass=0.
5. tx_ready held low 200 cycles in SEND -> tx_data stable and tx_valid high throughout; sent_count increments only on the handshake.
6. Reset asserted in WAIT_RX of word 3 -> next cycle all outputs 0; no done pulse. A following start with PATTERN=1, SEED=0 gives first word 8'h01.
